// File: rtl/lut_prod_accumulator.sv
// lut_prod_accumulator
// Sums N_TERMS consecutive 16-bit products from the LUT multiplier and
// presents the total on a registered valid/ready output. clear_i aborts the
// current accumulation or result in any state.
// Optional feature macro: ACC_SAT_EN (saturating add with sticky ovf_o).
// Without the macro the add wraps modulo 2^ACC_W and ovf_o is tied low.
//
// state      | meaning
// ST_COLLECT | accepting products, acc_q holds the running partial sum
// ST_HOLD    | full sum presented on acc_o, waiting for acc_ready_i
module lut_prod_accumulator #(
    parameter int  N_TERMS = 8,
    parameter int  ACC_W   = 19,
    localparam int CNT_W   = $clog2(N_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic [15:0]      prod_i,
    input  logic             prod_valid_i,
    output logic             prod_ready_o,
    output logic [ACC_W-1:0] acc_o,
    output logic             acc_valid_o,
    input  logic             acc_ready_i,
    output logic [CNT_W-1:0] term_cnt_o,
    output logic             ovf_o
);

    typedef enum logic {ST_COLLECT, ST_HOLD} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_sum;
    logic             prod_hs;
    logic             out_hs;
    logic             last_term;

    assign prod_hs   = prod_valid_i && prod_ready_o;
    assign out_hs    = acc_valid_o && acc_ready_i;
    assign last_term = (cnt_q == CNT_W'(N_TERMS - 1));

`ifdef ACC_SAT_EN
    logic [ACC_W:0] prod_ext;
    logic [ACC_W:0] sum_wide;
    logic           sat_hit;
    logic           ovf_q, ovf_d;

    // Add one bit of headroom, then clamp to all-ones when it is used.
    always_comb begin
        prod_ext       = '0;
        prod_ext[15:0] = prod_i;
        sum_wide       = {1'b0, acc_q} + prod_ext;
        sat_hit        = sum_wide[ACC_W];
        acc_sum        = sat_hit ? '1 : sum_wide[ACC_W-1:0];
    end

    // Sticky overflow flag; cleared with the result it belongs to.
    always_comb begin
        ovf_d = ovf_q;
        if (clear_i || out_hs) begin
            ovf_d = 1'b0;
        end else if (prod_hs && sat_hit) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    logic [ACC_W-1:0] prod_ext;

    // Zero-extend the product and wrap on overflow.
    always_comb begin
        prod_ext       = '0;
        prod_ext[15:0] = prod_i;
        acc_sum        = acc_q + prod_ext;
    end

    assign ovf_o = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear_i overrides everything and returns to collect.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_COLLECT;
        end else begin
            case (state_q)
                ST_COLLECT: if (prod_hs && last_term) state_d = ST_HOLD;
                ST_HOLD:    if (acc_ready_i)          state_d = ST_COLLECT;
                default:    state_d = ST_COLLECT;
            endcase
        end
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        prod_ready_o = 1'b0;
        acc_valid_o  = 1'b0;
        case (state_q)
            ST_COLLECT: prod_ready_o = !clear_i;
            ST_HOLD:    acc_valid_o  = 1'b1;
            default:    prod_ready_o = 1'b0;
        endcase
    end

    // Accumulator and term counter next values.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear_i || out_hs) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (prod_hs) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o      = acc_q;
    assign term_cnt_o = cnt_q;

endmodule

// File: tb/tb_lut_prod_accumulator.sv
module tb_lut_prod_accumulator;

    localparam int N = 8;
    localparam int W = 19;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_i = 1'b0;
    logic [15:0]   prod_i = '0;
    logic          prod_valid_i = 1'b0;
    logic          acc_ready_i = 1'b0;
    logic          prod_ready_o;
    logic [W-1:0]  acc_o;
    logic          acc_valid_o;
    logic [3:0]    term_cnt_o;
    logic          ovf_o;

    // narrow instance for the overflow behaviour
    logic          s_clear_i = 1'b0;
    logic [15:0]   s_prod_i = '0;
    logic          s_prod_valid_i = 1'b0;
    logic          s_acc_ready_i = 1'b0;
    logic          s_prod_ready_o;
    logic [16:0]   s_acc_o;
    logic          s_acc_valid_o;
    logic [2:0]    s_term_cnt_o;
    logic          s_ovf_o;

    typedef struct {
        logic [W-1:0] acc;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

`ifdef ACC_SAT_EN
    localparam logic [16:0] S_EXP_ACC = 17'h1FFFF;
    localparam logic        S_EXP_OVF = 1'b1;
`else
    localparam logic [16:0] S_EXP_ACC = 17'h1FFFC;
    localparam logic        S_EXP_OVF = 1'b0;
`endif

    lut_prod_accumulator #(.N_TERMS(N), .ACC_W(W)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear_i),
        .prod_i       (prod_i),
        .prod_valid_i (prod_valid_i),
        .prod_ready_o (prod_ready_o),
        .acc_o        (acc_o),
        .acc_valid_o  (acc_valid_o),
        .acc_ready_i  (acc_ready_i),
        .term_cnt_o   (term_cnt_o),
        .ovf_o        (ovf_o)
    );

    lut_prod_accumulator #(.N_TERMS(4), .ACC_W(17)) u_dut17 (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (s_clear_i),
        .prod_i       (s_prod_i),
        .prod_valid_i (s_prod_valid_i),
        .prod_ready_o (s_prod_ready_o),
        .acc_o        (s_acc_o),
        .acc_valid_o  (s_acc_valid_o),
        .acc_ready_i  (s_acc_ready_i),
        .term_cnt_o   (s_term_cnt_o),
        .ovf_o        (s_ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted result is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && acc_valid_o && acc_ready_i && !clear_i) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL result_unexpected actual=%0h required=none", acc_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_acc", 32'(acc_o), 32'(e.acc));
                chk("result_ovf", 32'(ovf_o), 32'(e.ovf));
            end
        end
    end

    task automatic send(input logic [15:0] v);
        prod_i = v;
        prod_valid_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (prod_ready_o) begin
                @(posedge clk);
                #1;
                prod_valid_i = 1'b0;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL send_timeout actual=not_accepted required=accepted value=%0h", v);
        prod_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held with traffic offered
        prod_valid_i = 1'b1;
        prod_i = 16'h1234;
        acc_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_acc_valid", 32'(acc_valid_o), 0);
        chk("rst_term_cnt", 32'(term_cnt_o), 0);
        chk("rst_ovf", 32'(ovf_o), 0);
        prod_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_prod_ready", 32'(prod_ready_o), 1);
        chk("rel_acc_valid", 32'(acc_valid_o), 0);
        chk("rel_acc", 32'(acc_o), 0);
        @(posedge clk); #1;

        // basic: 1..8 back-to-back
        sb.push_back('{acc: 19'd36, ovf: 1'b0});
        for (int v = 1; v <= 8; v++) send(16'(v));
        @(negedge clk);
        chk("basic_valid", 32'(acc_valid_o), 1);
        chk("basic_cnt", 32'(term_cnt_o), 8);
        chk("basic_ready_low", 32'(prod_ready_o), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("basic_valid_1cyc", 32'(acc_valid_o), 0);
        chk("basic_ready_back", 32'(prod_ready_o), 1);
        chk("basic_cnt_zero", 32'(term_cnt_o), 0);
        @(posedge clk); #1;

        // backpressure: 8x FFFF held for 5 cycles
        acc_ready_i = 1'b0;
        sb.push_back('{acc: 19'h7FFF8, ovf: 1'b0});
        for (int v = 0; v < 8; v++) send(16'hFFFF);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", 32'(acc_valid_o), 1);
            chk("bp_acc", 32'(acc_o), 32'h7FFF8);
            chk("bp_ready_low", 32'(prod_ready_o), 0);
        end
        @(posedge clk); #1;
        acc_ready_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_released", 32'(acc_valid_o), 0);
        @(posedge clk); #1;

        // bubbles: 8 products of 100 with a gap between each
        sb.push_back('{acc: 19'd800, ovf: 1'b0});
        for (int i = 0; i < 8; i++) begin
            send(16'd100);
            @(negedge clk);
            chk("bub_cnt_hs", 32'(term_cnt_o), 32'(i + 1));
            if (i < 7) begin
                @(posedge clk); #1;
                chk("bub_cnt_idle", 32'(term_cnt_o), 32'(i + 1));
            end
        end
        @(posedge clk); #1;
        chk("bub_cnt_after", 32'(term_cnt_o), 0);

        // clear mid-accumulation
        for (int i = 0; i < 3; i++) send(16'd2);
        clear_i = 1'b1;
        prod_valid_i = 1'b1;
        prod_i = 16'd2;
        @(negedge clk);
        chk("clr_ready_low", 32'(prod_ready_o), 0);
        @(posedge clk); #1;
        clear_i = 1'b0;
        prod_valid_i = 1'b0;
        chk("clr_cnt", 32'(term_cnt_o), 0);
        chk("clr_acc", 32'(acc_o), 0);

        // clear in HOLD with acc_ready_i high drops the result
        acc_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) send(16'd7);
        @(negedge clk);
        chk("clr_hold_valid", 32'(acc_valid_o), 1);
        @(posedge clk); #1;
        acc_ready_i = 1'b1;
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        chk("clr_hold_drop", 32'(acc_valid_o), 0);
        chk("clr_hold_cnt", 32'(term_cnt_o), 0);

        sb.push_back('{acc: 19'd16, ovf: 1'b0});
        for (int i = 0; i < 8; i++) send(16'd2);
        @(negedge clk);
        chk("clr_next_valid", 32'(acc_valid_o), 1);
        @(posedge clk); #1;

        // narrow accumulator: 4x FFFF into 17 bits
        s_prod_i = 16'hFFFF;
        s_prod_valid_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        s_prod_valid_i = 1'b0;
        @(negedge clk);
        chk("w17_valid", 32'(s_acc_valid_o), 1);
        chk("w17_acc", 32'(s_acc_o), 32'(S_EXP_ACC));
        chk("w17_ovf", 32'(s_ovf_o), 32'(S_EXP_OVF));
        chk("w17_cnt", 32'(s_term_cnt_o), 4);
        @(posedge clk); #1;
        s_acc_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("w17_consumed", 32'(s_acc_valid_o), 0);
        chk("w17_ovf_clr", 32'(s_ovf_o), 0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
